button_bank_press_detector: RTL and testbench

//  Multi-channel successor to the single-button press detector: CHANNELS independent debounced

---
 rtl/button_pkg.sv | 40 ++++
 rtl/button_press_channel.sv | 140 ++++++++++++++
 rtl/button_bank_press_detector.sv | 52 +++++
 tb/tb_button_bank_press_detector.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the button press detector bank: per-channel state
// encoding, logic level names and counter width helpers.
package button_pkg;

  // Per-channel press FSM states.
  typedef enum logic [1:0] {
    WAIT_UP  = 2'd0,  // waiting for the button to be seen released
    BTN_UP   = 2'd1,  // armed, button released
    DEBOUNCE = 2'd2,  // counting consecutive high samples
    PRESSED  = 2'd3   // press latched, waiting for acknowledge
  } button_state_e;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Width of a saturating counter that must hold values 0..max_val (min 1 bit).
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  // Width of an index able to address n channels (min 1 bit).
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_press_channel.sv
// One debounced press latch: Moore FSM with a debounce counter, a long-press
// counter and a "still held since the latch" bit. Outputs are registered from
// the next-state values so they change on the same edge as the state.
module button_press_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int LONG_CYCLES     = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_button_down,
  input  logic i_ack_press,
  output logic o_was_pressed,
  output logic o_was_long
);

  localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int LONG_W = cnt_width(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
  // With LONG_CYCLES=0 the long flag is permanently low.
  localparam logic LONG_EN = (LONG_CYCLES > 0) ? 1'b1 : 1'b0;

  button_state_e     r_state;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [LONG_W-1:0] r_long_cnt;
  logic              r_held;
  logic              r_was_pressed;
  logic              r_was_long;

  button_state_e     w_state_nxt;
  logic [DEB_W-1:0]  w_deb_cnt_nxt;
  logic [LONG_W-1:0] w_long_cnt_nxt;
  logic              w_held_nxt;
  logic              w_was_pressed_nxt;
  logic              w_was_long_nxt;

  // Next-state and counter update logic for the press FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_deb_cnt_nxt  = r_deb_cnt;
    w_long_cnt_nxt = r_long_cnt;
    w_held_nxt     = r_held;
    case (r_state)
      WAIT_UP: begin
        // A button already down (at reset or after ack) must be released first.
        w_deb_cnt_nxt  = {DEB_W{1'b0}};
        w_long_cnt_nxt = {LONG_W{1'b0}};
        w_held_nxt     = 1'b0;
        if (i_button_down == LOW) begin
          w_state_nxt = BTN_UP;
        end else begin
          w_state_nxt = WAIT_UP;
        end
      end
      BTN_UP: begin
        if (i_button_down == HIGH) begin
          w_state_nxt   = DEBOUNCE;
          w_deb_cnt_nxt = DEB_W'(1);
        end else begin
          w_state_nxt   = BTN_UP;
          w_deb_cnt_nxt = {DEB_W{1'b0}};
        end
      end
      DEBOUNCE: begin
        if (i_button_down == LOW) begin
          // Bounce: any low sample restarts the qualification from scratch.
          w_state_nxt   = BTN_UP;
          w_deb_cnt_nxt = {DEB_W{1'b0}};
        end else if (r_deb_cnt < DEB_MAX) begin
          w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
        end else begin
          w_state_nxt    = PRESSED;
          w_deb_cnt_nxt  = {DEB_W{1'b0}};
          w_long_cnt_nxt = {LONG_W{1'b0}};
          w_held_nxt     = 1'b1;
        end
      end
      PRESSED: begin
        if (i_ack_press == HIGH) begin
          // Acknowledge wins over long counting and clears both flags.
          w_state_nxt    = WAIT_UP;
          w_long_cnt_nxt = {LONG_W{1'b0}};
          w_held_nxt     = 1'b0;
        end else if ((i_button_down == HIGH) && r_held) begin
          if (r_long_cnt < LONG_MAX) begin
            w_long_cnt_nxt = r_long_cnt + LONG_W'(1);
          end else begin
            w_long_cnt_nxt = r_long_cnt;
          end
        end else if (i_button_down == LOW) begin
          // Once released, a re-press of the same latched press never counts.
          w_held_nxt = 1'b0;
        end else begin
          w_held_nxt = r_held;
        end
      end
      default: begin
        w_state_nxt    = WAIT_UP;
        w_deb_cnt_nxt  = {DEB_W{1'b0}};
        w_long_cnt_nxt = {LONG_W{1'b0}};
        w_held_nxt     = 1'b0;
      end
    endcase
  end

  // Output flags derived from next-state values so they register with the state.
  always_comb begin
    w_was_pressed_nxt = (w_state_nxt == PRESSED) ? 1'b1 : 1'b0;
    if (LONG_EN && (w_state_nxt == PRESSED) && (w_long_cnt_nxt == LONG_MAX)) begin
      w_was_long_nxt = 1'b1;
    end else begin
      w_was_long_nxt = 1'b0;
    end
  end

  // State, counters and output flags with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= WAIT_UP;
      r_deb_cnt     <= {DEB_W{1'b0}};
      r_long_cnt    <= {LONG_W{1'b0}};
      r_held        <= 1'b0;
      r_was_pressed <= 1'b0;
      r_was_long    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_deb_cnt     <= w_deb_cnt_nxt;
      r_long_cnt    <= w_long_cnt_nxt;
      r_held        <= w_held_nxt;
      r_was_pressed <= w_was_pressed_nxt;
      r_was_long    <= w_was_long_nxt;
    end
  end

  assign o_was_pressed = r_was_pressed;
  assign o_was_long    = r_was_long;

endmodule

// File: rtl/button_bank_press_detector.sv
// Bank of independent debounced press latches with a priority summary so a
// single consumer FSM can service the lowest pending channel first.
module button_bank_press_detector
  import button_pkg::*;
#(
  parameter int  CHANNELS        = 4,
  parameter int  DEBOUNCE_CYCLES = 3,
  parameter int  LONG_CYCLES     = 16,
  localparam int IDX_W           = idx_width(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button_down,
  input  logic [CHANNELS-1:0] ack_press,
  output logic [CHANNELS-1:0] was_pressed,
  output logic [CHANNELS-1:0] was_long,
  output logic                any_pressed,
  output logic [IDX_W-1:0]    first_pressed
);

  logic [IDX_W-1:0] w_first;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    button_press_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .clock         (clock),
      .reset         (reset),
      .i_button_down (button_down[g]),
      .i_ack_press   (ack_press[g]),
      .o_was_pressed (was_pressed[g]),
      .o_was_long    (was_long[g])
    );
  end

  // Priority encoder: scanning from the top down leaves the lowest set index.
  always_comb begin
    w_first = {IDX_W{1'b0}};
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (was_pressed[i]) begin
        w_first = IDX_W'(i);
      end else begin
        w_first = w_first;
      end
    end
  end

  assign first_pressed = w_first;
  assign any_pressed   = |was_pressed;

endmodule

// File: tb/tb_button_bank_press_detector.sv
// Scoreboard bench for the button bank: the driver runs a behavioural model
// and queues expected outputs; a monitor compares each cycle's DUT outputs.
module tb_button_bank_press_detector;
  import button_pkg::*;

  localparam int NCH  = 4;
  localparam int DEB  = 3;
  localparam int LONG = 16;

  logic           clock;
  logic           reset;
  logic [NCH-1:0] button_down;
  logic [NCH-1:0] ack_press;
  logic [NCH-1:0] was_pressed;
  logic [NCH-1:0] was_long;
  logic           any_pressed;
  logic [1:0]     first_pressed;

  button_bank_press_detector #(
    .CHANNELS        (NCH),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .button_down   (button_down),
    .ack_press     (ack_press),
    .was_pressed   (was_pressed),
    .was_long      (was_long),
    .any_pressed   (any_pressed),
    .first_pressed (first_pressed)
  );

  logic [7:0] dut_states;
  assign dut_states = {dut.g_ch[3].u_ch.r_state, dut.g_ch[2].u_ch.r_state,
                       dut.g_ch[1].u_ch.r_state, dut.g_ch[0].u_ch.r_state};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] wp;
    logic [3:0] wl;
    logic       any;
    logic [1:0] first;
    logic [7:0] states;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   running  = 1'b0;

  // Behavioural model: "armed" means a release has been seen since the last
  // reset/ack; run counts consecutive high samples while armed.
  bit m_armed[NCH];
  int m_run[NCH];
  bit m_latched[NCH];
  bit m_held[NCH];
  int m_hold_len[NCH];

  task automatic model_step(input logic rst, input logic [3:0] bd, input logic [3:0] ack);
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        m_armed[i] = 0; m_run[i] = 0; m_latched[i] = 0; m_held[i] = 0; m_hold_len[i] = 0;
      end else if (m_latched[i]) begin
        if (ack[i]) begin
          m_latched[i] = 0; m_armed[i] = 0; m_run[i] = 0; m_held[i] = 0; m_hold_len[i] = 0;
        end else if (bd[i] && m_held[i]) begin
          m_hold_len[i] = (m_hold_len[i] + 1 > LONG) ? LONG : m_hold_len[i] + 1;
        end else if (!bd[i]) begin
          m_held[i] = 0;
        end
      end else if (!m_armed[i]) begin
        if (!bd[i]) begin
          m_armed[i] = 1; m_run[i] = 0;
        end
      end else if (bd[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DEB + 1) begin
          m_latched[i] = 1; m_held[i] = 1; m_hold_len[i] = 0; m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    bit found;
    e = '0;
    found = 0;
    for (int i = 0; i < NCH; i++) begin
      e.wp[i] = m_latched[i];
      e.wl[i] = (LONG > 0) && m_latched[i] && (m_hold_len[i] == LONG);
      if (m_latched[i])            e.states[2*i +: 2] = PRESSED;
      else if (!m_armed[i])        e.states[2*i +: 2] = WAIT_UP;
      else if (m_run[i] == 0)      e.states[2*i +: 2] = BTN_UP;
      else                         e.states[2*i +: 2] = DEBOUNCE;
      if (m_latched[i] && !found) begin
        e.first = 2'(i);
        found = 1;
      end
    end
    e.any = found;
    return e;
  endfunction

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic step(input logic rst, input logic [3:0] bd, input logic [3:0] ack);
    @(negedge clock);
    reset       = rst;
    button_down = bd;
    ack_press   = ack;
    running     = 1'b1;
    model_step(rst, bd, ack);
    sb_q.push_back(model_expect());
  endtask

  task automatic steps(input int n, input logic [3:0] bd, input logic [3:0] ack);
    for (int k = 0; k < n; k++) step(1'b0, bd, ack);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (running) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("was_pressed",   int'(was_pressed),   int'(e.wp));
          chk("was_long",      int'(was_long),      int'(e.wl));
          chk("any_pressed",   int'(any_pressed),   int'(e.any));
          chk("first_pressed", int'(first_pressed), int'(e.first));
          chk("states",        int'(dut_states),    int'(e.states));
        end
      end
    end
  end

  initial begin
    logic [3:0] rb, ra;
    reset = 1'b1; button_down = 4'b0000; ack_press = 4'b0000;
    // 1. reset with all buttons up, then WAIT_UP -> BTN_UP
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b1, 4'b0000, 4'b0000);
    steps(2, 4'b0000, 4'b0000);
    // 2. ch0 press, latency, ack, stay WAIT_UP until release
    steps(6, 4'b0001, 4'b0000);
    steps(1, 4'b0001, 4'b0001);
    steps(3, 4'b0001, 4'b0000);
    steps(2, 4'b0000, 4'b0000);
    // 3. bounce on ch1 for 1, 2, 3 high samples
    for (int n = 1; n <= 3; n++) begin
      steps(n, 4'b0010, 4'b0000);
      steps(2, 4'b0000, 4'b0000);
    end
    // 4. long press on ch2, then interrupted hold
    steps(4 + LONG + 3, 4'b0100, 4'b0000);
    steps(1, 4'b0100, 4'b0100);
    steps(2, 4'b0000, 4'b0000);
    steps(4 + 10, 4'b0100, 4'b0000);
    steps(2, 4'b0000, 4'b0000);
    steps(LONG + 4, 4'b0100, 4'b0000);
    steps(1, 4'b0000, 4'b0100);
    steps(2, 4'b0000, 4'b0000);
    // 5. priority between ch1 and ch3 latching together
    steps(6, 4'b1010, 4'b0000);
    steps(1, 4'b1010, 4'b0010);
    steps(2, 4'b1010, 4'b0000);
    steps(1, 4'b1010, 4'b1000);
    steps(2, 4'b0000, 4'b0000);
    // 6. reset mid-debounce / mid-press, held button, ack in BTN_UP
    steps(6, 4'b0100, 4'b0000);
    steps(2, 4'b0101, 4'b0000);
    step(1'b1, 4'b0101, 4'b0000);
    steps(8, 4'b0101, 4'b0000);
    steps(2, 4'b0000, 4'b0101);
    steps(6, 4'b0001, 4'b0000);
    steps(1, 4'b0001, 4'b0001);
    steps(2, 4'b0000, 4'b0000);
    // random phase: slowly toggling buttons, sparse acks, rare resets
    rb = 4'b0000;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(5, 0) == 0) rb[i] = ~rb[i];
        ra[i] = ($urandom_range(7, 0) == 0);
      end
      step(($urandom_range(199, 0) == 0), rb, ra);
    end
    @(posedge clock);
    #2;
    running = 1'b0;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
